multdiv: RTL and testbench



---
 rtl/multdiv_pkg.sv | 26 ++
 rtl/multdiv_if.sv | 29 ++
 rtl/multdiv_addsub.sv | 25 ++
 rtl/multdiv.sv | 149 ++++++++++++++
 tb/tb_multdiv.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_t    - sequencer states
//   DEF_WIDTH  - default operand/result width (also the iteration count)
//   MIN_INT    - most-negative value at the default width
//   cnt_width  - width of the iteration counter for a given operand width
package multdiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] MIN_INT = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand/control/result bundle between the execute stage and multdiv.
//   data_operandA/B  - signed operands (multiplicand/dividend, multiplier/divisor)
//   ctrl_MULT/DIV    - start pulses
//   data_result      - registered result, held until the next completion
//   data_exception   - registered overflow / divide-by-zero flag
//   data_resultRDY   - one-cycle completion pulse
//   busy             - operation in flight
interface multdiv_if #(parameter int WIDTH = multdiv_pkg::DEF_WIDTH);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: W-bit combinational add/subtract with carry-out.
//   a, b  - operands
//   sub   - 1: a - b (cout=1 means no borrow), 0: a + b
//   sum   - low W bits of the result
//   cout  - carry out of bit W-1
module multdiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
  end

  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed multiply / restoring divide, fixed WIDTH+1 cycle latency.
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset; aborts any operation in flight
//   bus      - multdiv_if slave: operands, start pulses, result/exception/ready/busy
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | one shift-add step per clock on the {hi,lo} accumulator
// DIV   | one restoring quotient bit per clock; hi is remainder, lo is quotient
// FIX   | apply result sign, register result and exception
// DONE  | result-ready cycle; accepts a new start directly
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]     ONE_W1 = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_W2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mag_b;
  logic             neg_res;
  logic             div_zero;
  logic             is_div;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_sub;
  logic [WIDTH:0]     add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     quot_s;
  logic [WIDTH:0]     prod_top;
  logic               mul_ovf;
  logic               div_ovf;
  logic               start;

  // Unsigned magnitude: most-negative maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  // Multiply adds |B| into hi when the current multiplier bit is set;
  // divide trial-subtracts |B| from the remainder shifted left by one dividend bit.
  always_comb begin
    add_a   = {1'b0, hi};
    add_b   = lo[0] ? {1'b0, mag_b} : '0;
    add_sub = 1'b0;
    if (state == DIV) begin
      add_a   = {hi, lo[WIDTH-1]};
      add_b   = {1'b0, mag_b};
      add_sub = 1'b1;
    end
  end

  multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Quotient is kept WIDTH+1 wide so MIN / -1 shows up as a positive overflow.
  always_comb begin
    prod_s   = neg_res ? (~{hi, lo} + ONE_W2) : {hi, lo};
    quot_s   = neg_res ? (~{1'b0, lo} + ONE_W1) : {1'b0, lo};
    prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    mul_ovf  = !((&prod_top) || !(|prod_top));
    div_ovf  = quot_s[WIDTH] ^ quot_s[WIDTH-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      counter            <= '0;
      hi                 <= '0;
      lo                 <= '0;
      mag_b              <= '0;
      neg_res            <= 1'b0;
      div_zero           <= 1'b0;
      is_div             <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.data_resultRDY <= 1'b0;
          if (start) begin
            state    <= bus.ctrl_MULT ? MUL : DIV;
            is_div   <= !bus.ctrl_MULT;
            bus.busy <= 1'b1;
            counter  <= '0;
            hi       <= '0;
            lo       <= mag(bus.data_operandA);
            mag_b    <= mag(bus.data_operandB);
            neg_res  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_zero <= (bus.data_operandB == '0);
          end else begin
            state <= IDLE;
          end
        end
        MUL, DIV: begin
          if (state == DIV) begin
            hi <= add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], add_cout};
          end else begin
            hi <= add_sum[WIDTH:1];
            lo <= {add_sum[0], lo[WIDTH-1:1]};
          end
          counter <= counter + 1'b1;
          if (counter == LAST) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            bus.data_result    <= prod_s[WIDTH-1:0];
            bus.data_exception <= mul_ovf;
          end else if (div_zero) begin
            bus.data_result    <= '0;
            bus.data_exception <= 1'b1;
          end else begin
            bus.data_result    <= quot_s[WIDTH-1:0];
            bus.data_exception <= div_ovf;
          end
          bus.busy           <= 1'b0;
          bus.data_resultRDY <= 1'b1;
          state              <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
module tb_multdiv;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  exp_t mon_e;

  multdiv_if #(.WIDTH(32)) dut_if ();

  multdiv #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dut_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (dut_if.data_resultRDY) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rdy_queue_depth", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", 64'(dut_if.data_result), 64'(mon_e.res));
        check("exception", 64'(dut_if.data_exception), 64'(mon_e.exc));
        check("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Called at a negedge; the start is sampled on the next posedge (E0).
  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_e, input bit push);
    exp_t e;
    dut_if.ctrl_MULT     = m;
    dut_if.ctrl_DIV      = d;
    dut_if.data_operandA = a;
    dut_if.data_operandB = b;
    if (push) begin
      e.res = exp_r;
      e.exc = exp_e;
      e.due = cyc + 34;
      sb_q.push_back(e);
    end
  endtask

  // Returns at the negedge where data_resultRDY is seen. At iteration inj a
  // divide start with fresh operands is injected into the running operation.
  task automatic finish_op(input int inj);
    int cnt;
    bit got;
    cnt = 0;
    got = 0;
    @(negedge clock);
    dut_if.ctrl_MULT = 1'b0;
    dut_if.ctrl_DIV  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dut_if.data_resultRDY) begin
        got = 1;
        break;
      end
      if (dut_if.busy) cnt++;
      if (i == inj) begin
        dut_if.ctrl_DIV      = 1'b1;
        dut_if.data_operandA = 32'd100;
        dut_if.data_operandB = 32'd7;
      end
      if (i == inj + 1) dut_if.ctrl_DIV = 1'b0;
      @(negedge clock);
    end
    check("rdy_seen", 64'(got), 64'd1);
    check("busy_cycles", 64'(cnt), 64'd33);
    check("busy_at_rdy", 64'(dut_if.busy), 64'd0);
  endtask

  task automatic post_check(input logic [31:0] exp_r, input logic exp_e);
    @(negedge clock);
    check("rdy_pulse_width", 64'(dut_if.data_resultRDY), 64'd0);
    check("result_hold", 64'(dut_if.data_result), 64'(exp_r));
    check("exception_hold", 64'(dut_if.data_exception), 64'(exp_e));
  endtask

  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_e, input int inj);
    start(m, d, a, b, exp_r, exp_e, 1'b1);
    finish_op(inj);
    post_check(exp_r, exp_e);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    dut_if.ctrl_MULT     = 1'b0;
    dut_if.ctrl_DIV      = 1'b0;
    dut_if.data_operandA = '0;
    dut_if.data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_result", 64'(dut_if.data_result), 64'd0);
    check("reset_exception", 64'(dut_if.data_exception), 64'd0);
    check("reset_rdy", 64'(dut_if.data_resultRDY), 64'd0);
    check("reset_busy", 64'(dut_if.busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // multiplies
    do_op(1, 0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, -1);
    do_op(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, -1);
    do_op(1, 0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, -1);
    do_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, -1);
    do_op(1, 0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, -1);
    do_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, -1);

    // divides
    do_op(0, 1, 32'hFFFFFFD5, 32'd5,        32'hFFFFFFF8, 1'b0, -1);
    do_op(0, 1, 32'd43,       32'hFFFFFFFB, 32'hFFFFFFF8, 1'b0, -1);
    do_op(0, 1, 32'd4,        32'd7,        32'd0,        1'b0, -1);
    do_op(0, 1, 32'd100,      32'd0,        32'd0,        1'b1, -1);
    do_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, -1);
    do_op(0, 1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, -1);

    // start and operand changes while busy are ignored
    do_op(1, 0, 32'd3, 32'd3, 32'd9, 1'b0, 9);
    // both starts high: multiply wins (a divide would give -3)
    do_op(1, 1, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFF4, 1'b0, -1);

    // reset in the middle of a divide
    start(0, 1, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    dut_if.ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    check("busy_before_abort", 64'(dut_if.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(dut_if.busy), 64'd0);
    check("abort_rdy", 64'(dut_if.data_resultRDY), 64'd0);
    check("abort_result", 64'(dut_if.data_result), 64'd0);
    check("abort_exception", 64'(dut_if.data_exception), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("idle_after_abort", 64'(dut_if.busy), 64'd0);
    do_op(1, 0, 32'd3, 32'd3, 32'd9, 1'b0, -1);

    // back-to-back: new start in the DONE cycle
    start(1, 0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b1);
    finish_op(-1);
    start(0, 1, 32'hFFFFFFEC, 32'd4, 32'hFFFFFFFB, 1'b0, 1'b1);
    finish_op(-1);
    post_check(32'hFFFFFFFB, 1'b0);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
